alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Registered output stage that sits directly downstream of the combinational shifter in the parameterized ALU.
- Captures the shifter result together with its shift_op tag and derives zero and negative flags.
- Presents result and flags to the consumer over a valid/ready handshake.
- Decouples the combinational ALU path from downstream backpressure with a 2-entry skid buffer (main + skid registers) and counts delivered results.

Parameters:
- DATA_WIDTH, 8, width of result datapath; must match the shifter's DATA_WIDTH.
- COUNT_WIDTH, 16, width of the saturating delivered-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept; registered, high iff skid register empty
- in_result  input  DATA_WIDTH  shifter result
- in_shift_op  input  2  shift_op tag: 00 SLL, 01 SRL, 10 SRA, 11 pass
- out_valid  output  1  main register holds a result
- out_ready  input  1  downstream accepts
- out_result  output  DATA_WIDTH  registered result
- out_op  output  2  registered shift_op tag
- out_zero  output  1  out_result == 0
- out_negative  output  1  out_result[DATA_WIDTH-1]
- occupancy  output  2  entries held: 0, 1 or 2
- result_count  output  COUNT_WIDTH  output handshakes since reset, saturating

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Handshake events:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - Data fields are don't-care when the matching valid is low.
- Reset (rst=1 at a clock edge), all outputs:
  - out_valid=0, in_ready=1, occupancy=0, result_count=0.
  - out_result=0, out_op=0, out_zero=1, out_negative=0.
  - Reset mid-operation discards both entries and takes priority over any same-cycle handshake.
- Flags are computed on capture and stored as registers alongside result and op, so out_* fields are always mutually consistent.
- Latency: a result accepted at edge N appears on out_* after edge N when the stage was empty (1-cycle latency). No combinational path from in_* to out_*.
- States (occupancy):
  - EMPTY(0): out_valid=0, in_ready=1. Accept -> ONE, data into main.
  - ONE(1): out_valid=1, in_ready=1.
    - Accept & Deliver -> ONE, main loads new data.
    - Accept only -> TWO, new data into skid.
    - Deliver only -> EMPTY.
    - Neither -> hold.
  - TWO(2): out_valid=1, in_ready=0, so no accept is possible.
    - Deliver -> ONE, skid moves to main.
    - Otherwise hold.
- Ordering: strict FIFO. Skid data never overtakes main.
- Stability: while out_valid=1 and out_ready=0, out_result, out_op and the flags must not change.
- in_ready is a function of registered state only. It never depends combinationally on out_ready or in_valid.
- Throughput: 1 result/cycle sustained when out_ready is held high.
- result_count: increments by 1 on each Deliver; holds at 2^COUNT_WIDTH-1 (no wrap).
- in_valid while in_ready=0 has no effect. Upstream must hold its data; the stage does not capture it.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, result_count=0, out_zero=1.
- Single pass, DATA_WIDTH=8:
  - Stimulus: in_result=8'hF0, in_shift_op=2'b10, one accept, out_ready=1.
  - Response: next cycle out_valid=1, out_result=F0, out_op=10, out_negative=1, out_zero=0; after deliver, occupancy=0 and result_count=1.
- Backpressure fill:
  - Stimulus: out_ready=0, accept 8'h01 then 8'h00.
  - Response: occupancy=2, in_ready=0; a third in_valid with 8'h55 is ignored.
  - Then out_ready=1: deliveries are 01 (zero=0), then 00 (zero=1), in order; in_ready returns to 1 one cycle after the first deliver.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with an incrementing result -> one delivery per cycle after 1-cycle latency, values in order, result_count=20.
- Random stall: random in_valid/out_ready over 1000 cycles against a scoreboard queue -> no loss, duplication or reorder; outputs stable while stalled.
- Reset mid-operation: occupancy=2, assert rst with out_ready=1 -> next cycle occupancy=0, out_valid=0, result_count=0. Saturation check with COUNT_WIDTH=3: after 9 deliveries result_count=7.

Source files
------------

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Brief    : Registered ALU output stage. Captures the shifter result and its
//            shift_op tag, derives zero/negative flags on capture, and presents
//            them over valid/ready through a 2-entry (main + skid) buffer.
//            Also keeps a saturating count of delivered results.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_result,
    input  logic [1:0]             in_shift_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_result,
    output logic [1:0]             out_op,
    output logic                   out_zero,
    output logic                   out_negative,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] result_count
);

    // Occupancy-encoded states: the state value is the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] C_COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] C_COUNT_MAX = {COUNT_WIDTH{1'b1}};

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;

    logic [DATA_WIDTH-1:0]    main_result_q, main_result_d;
    logic [1:0]               main_op_q, main_op_d;
    logic                     main_zero_q, main_zero_d;
    logic                     main_neg_q, main_neg_d;

    logic [DATA_WIDTH-1:0]    skid_result_q, skid_result_d;
    logic [1:0]               skid_op_q, skid_op_d;
    logic                     skid_zero_q, skid_zero_d;
    logic                     skid_neg_q, skid_neg_d;

    logic [COUNT_WIDTH-1:0]   count_q, count_d;

    logic                     w_accept;
    logic                     w_deliver;
    logic                     w_in_zero;
    logic                     w_in_neg;

    assign out_valid    = (state_q != ST_EMPTY);
    assign in_ready     = in_ready_q;
    assign w_accept     = in_valid & in_ready_q;
    assign w_deliver    = out_valid & out_ready;

    // Flags are derived once, at capture, so they always travel with their data.
    assign w_in_zero    = (in_result == '0);
    assign w_in_neg     = in_result[DATA_WIDTH-1];

    assign out_result   = main_result_q;
    assign out_op       = main_op_q;
    assign out_zero     = main_zero_q;
    assign out_negative = main_neg_q;
    assign occupancy    = 2'(state_q);
    assign result_count = count_q;

    // Next-state, buffer steering and delivered-result counter.
    always_comb begin
        state_d       = state_q;
        main_result_d = main_result_q;
        main_op_d     = main_op_q;
        main_zero_d   = main_zero_q;
        main_neg_d    = main_neg_q;
        skid_result_d = skid_result_q;
        skid_op_d     = skid_op_q;
        skid_zero_d   = skid_zero_q;
        skid_neg_d    = skid_neg_q;
        count_d       = count_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    state_d       = ST_ONE;
                    main_result_d = in_result;
                    main_op_d     = in_shift_op;
                    main_zero_d   = w_in_zero;
                    main_neg_d    = w_in_neg;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    // Old head leaves this edge, so the new entry becomes head.
                    main_result_d = in_result;
                    main_op_d     = in_shift_op;
                    main_zero_d   = w_in_zero;
                    main_neg_d    = w_in_neg;
                end else if (w_accept) begin
                    // Head is stalled; park the newcomer behind it.
                    state_d       = ST_TWO;
                    skid_result_d = in_result;
                    skid_op_d     = in_shift_op;
                    skid_zero_d   = w_in_zero;
                    skid_neg_d    = w_in_neg;
                end else if (w_deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_deliver) begin
                    state_d       = ST_ONE;
                    main_result_d = skid_result_q;
                    main_op_d     = skid_op_q;
                    main_zero_d   = skid_zero_q;
                    main_neg_d    = skid_neg_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (w_deliver && (count_q != C_COUNT_MAX)) begin
            count_d = count_q + C_COUNT_ONE;
        end

        // in_ready is registered: it reflects whether the skid slot will be free.
        in_ready_d = (state_d != ST_TWO);
    end

    // State, buffer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            main_result_q <= '0;
            main_op_q     <= 2'b00;
            main_zero_q   <= 1'b1;
            main_neg_q    <= 1'b0;
            skid_result_q <= '0;
            skid_op_q     <= 2'b00;
            skid_zero_q   <= 1'b1;
            skid_neg_q    <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            main_result_q <= main_result_d;
            main_op_q     <= main_op_d;
            main_zero_q   <= main_zero_d;
            main_neg_q    <= main_neg_d;
            skid_result_q <= skid_result_d;
            skid_op_q     <= skid_op_d;
            skid_zero_q   <= skid_zero_d;
            skid_neg_q    <= skid_neg_d;
            count_q       <= count_d;
        end
    end

endmodule
`default_nettype wire
